// File: rtl/lcd1602_pkg.sv
// Shared types and init-sequence constants for the LCD1602 write sequencer.
package lcd1602_pkg;

  typedef enum logic [2:0] {PWRUP, LOAD, SETUP, PULSE, HOLD, WAIT, IDLE} state_t;

  localparam int         INIT_LEN = 6;
  localparam logic [7:0] CLR      = 8'h01;
  localparam logic [7:0] FUNC8    = 8'h38;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] ENTRY    = 8'h06;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return FUNC8;
      3'd3:             return DISP_ON;
      3'd4:             return CLR;
      default:          return ENTRY;
    endcase
  endfunction

  // The three wake-up writes and the clear need the long execution time.
  function automatic logic init_long(input logic [2:0] idx);
    return (idx <= 3'd2) || (idx == 3'd4);
  endfunction

  // Clear (0x01) and home (0x02/0x03) are the only slow instructions.
  function automatic logic cmd_long(input logic rs, input logic [5:0] hi);
    return !rs && (hi == 6'd0);
  endfunction

endpackage

// File: rtl/lcd1602_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module lcd1602_timer #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)             cnt <= RST_VAL;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd1602_ctrl.sv
// HD44780 / LCD1602 sequencer: power-up delay, init ROM, then a valid/ready byte-write port.
module lcd1602_ctrl
  import lcd1602_pkg::*;
#(
  parameter int SETUP_CYC  = 4,
  parameter int EN_CYC     = 25,
  parameter int HOLD_CYC   = 4,
  parameter int WAIT_SHORT = 2500,
  parameter int WAIT_LONG  = 250000,
  parameter int PWRUP_CYC  = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       init_done,
  output logic       busy,
  output logic       rs,
  output logic       rw,
  output logic       en,
  output logic [7:0] dat
);

  localparam int MAXC = (PWRUP_CYC > WAIT_LONG) ? PWRUP_CYC : WAIT_LONG;
  localparam int TW   = $clog2(MAXC) + 1;

  localparam logic [TW-1:0] T_SETUP = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] T_EN    = TW'(EN_CYC - 1);
  localparam logic [TW-1:0] T_HOLD  = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] T_SHORT = TW'(WAIT_SHORT - 1);
  localparam logic [TW-1:0] T_LONG  = TW'(WAIT_LONG - 1);
  localparam logic [TW-1:0] T_PWRUP = TW'(PWRUP_CYC - 1);

  state_t        state;
  logic [2:0]    idx;
  logic          req_rs;
  logic [7:0]    req_data;
  logic          long_q;
  logic          t_load;
  logic [TW-1:0] t_val;
  logic          t_done;

  assign rw = 1'b0;

  // Timer is reloaded on every phase change; its reset value covers PWRUP.
  always_comb begin
    t_load = 1'b0;
    t_val  = '0;
    case (state)
      LOAD:  begin t_load = 1'b1; t_val = T_SETUP; end
      SETUP: if (t_done) begin t_load = 1'b1; t_val = T_EN; end
      PULSE: if (t_done) begin t_load = 1'b1; t_val = T_HOLD; end
      HOLD:  if (t_done) begin t_load = 1'b1; t_val = long_q ? T_LONG : T_SHORT; end
      default: ;
    endcase
  end

  lcd1602_timer #(.W(TW), .RST_VAL(T_PWRUP)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PWRUP;
      idx       <= '0;
      req_rs    <= 1'b0;
      req_data  <= '0;
      long_q    <= 1'b0;
      rs        <= 1'b0;
      dat       <= '0;
      en        <= 1'b0;
      cmd_ready <= 1'b0;
      init_done <= 1'b0;
      busy      <= 1'b1;
    end else begin
      // Registered from the state, so en is a clean strobe one cycle behind PULSE.
      en <= (state == PULSE);
      case (state)
        PWRUP: if (t_done) state <= LOAD;
        LOAD: begin
          if (!init_done) begin
            rs     <= 1'b0;
            dat    <= init_byte(idx);
            long_q <= init_long(idx);
          end else begin
            rs     <= req_rs;
            dat    <= req_data;
            long_q <= cmd_long(req_rs, req_data[7:2]);
          end
          state <= SETUP;
        end
        SETUP: if (t_done) state <= PULSE;
        PULSE: if (t_done) state <= HOLD;
        HOLD:  if (t_done) state <= WAIT;
        WAIT: if (t_done) begin
          if (!init_done && idx != 3'(INIT_LEN - 1)) begin
            idx   <= idx + 3'd1;
            state <= LOAD;
          end else begin
            init_done <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        IDLE: if (cmd_valid && cmd_ready) begin
          req_rs    <= cmd_rs;
          req_data  <= cmd_data;
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          state     <= LOAD;
        end
        default: state <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd1602_ctrl.sv
// Self-checking bench for lcd1602_ctrl: timeline reference model plus literal timing checks.
module tb_lcd1602_ctrl;

  localparam int SU = 2, EN = 3, HO = 2, SH = 5, LO = 12, PW = 20;

  logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_rs = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, init_done, busy, rs, rw, en;
  logic [7:0] dat;

  lcd1602_ctrl #(
    .SETUP_CYC(SU), .EN_CYC(EN), .HOLD_CYC(HO),
    .WAIT_SHORT(SH), .WAIT_LONG(LO), .PWRUP_CYC(PW)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rs(cmd_rs), .cmd_data(cmd_data), .init_done(init_done), .busy(busy),
    .rs(rs), .rw(rw), .en(en), .dat(dat)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: each transfer is a timeline measured from the edge it enters LOAD.
  logic [7:0] rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  int         m_phase, m_t, m_step, m_acc_cyc, m_accepts, m_rst_edge;
  logic [7:0] m_byte, m_dat;
  logic       m_rsq, m_rs, m_done, m_ready;

  function automatic int wait_of(input int step, input logic r, input logic [7:0] d);
    if (step < 6) return (step <= 2 || step == 4) ? LO : SH;
    return (!r && d < 8'h04) ? LO : SH;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_phase = 0; m_t = 0; m_step = 0; m_dat = 8'h00; m_rs = 1'b0;
      m_done = 1'b0; m_ready = 1'b0; m_rst_edge = cyc; chk_on = 1'b1;
    end else begin
      case (m_phase)
        0: begin
          m_t++;
          if (m_t == PW) begin m_phase = 1; m_t = 0; m_step = 0; m_byte = rom[0]; m_rsq = 1'b0; end
        end
        1: begin
          m_t++;
          if (m_t == 1) begin m_dat = m_byte; m_rs = m_rsq; end
          if (m_t == 1 + SU + EN + HO + wait_of(m_step, m_rsq, m_byte)) begin
            if (m_step < 5) begin
              m_step++; m_t = 0; m_byte = rom[m_step]; m_rsq = 1'b0;
            end else begin
              m_done = 1'b1; m_phase = 2; m_ready = 1'b1;
            end
          end
        end
        default: if (cmd_valid) begin
          m_phase = 1; m_t = 0; m_step = 6; m_byte = cmd_data; m_rsq = cmd_rs;
          m_ready = 1'b0; m_acc_cyc = cyc; m_accepts++;
        end
      endcase
    end
  end

  // Per-cycle compare plus pulse / ready-return logging.
  int         pn = 0, rdy_cyc = 0;
  int         p_rise [256], p_fall [256];
  logic [7:0] p_dat [256];
  logic       p_rs [256];
  logic       en_prev = 1'b0, rdy_prev = 1'b0;

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("en", en, (m_phase == 1 && m_t >= SU + 2 && m_t <= SU + EN + 1));
      chk("rs", rs, m_rs);
      chk("dat", dat, m_dat);
      chk("rw", rw, 1'b0);
      chk("cmd_ready", cmd_ready, m_ready);
      chk("init_done", init_done, m_done);
      chk("busy", busy, (m_phase != 2));
      if (en && !en_prev && pn < 256) begin p_rise[pn] = cyc; p_dat[pn] = dat; p_rs[pn] = rs; end
      if (!en && en_prev && pn < 256) begin p_fall[pn] = cyc; pn++; end
      if (cmd_ready && !rdy_prev) rdy_cyc = cyc;
      en_prev = en; rdy_prev = cmd_ready;
    end
  end

  task automatic wait_init();
    int n = 0;
    while (init_done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) chk("init_timeout", 0, 1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) chk("ready_timeout", 0, 1);
  endtask

  task automatic check_init(input int base);
    int gap_exp [5] = '{17, 17, 17, 10, 17};
    chk("init_pulse_count", pn - base, 6);
    chk("init_first_rise", p_rise[base] - m_rst_edge, 24);
    for (int i = 0; i < 6; i++) begin
      chk("init_dat", p_dat[base+i], rom[i]);
      chk("init_rs", p_rs[base+i], 1'b0);
      chk("init_width", p_fall[base+i] - p_rise[base+i], 3);
      if (i < 5) chk("init_gap", p_rise[base+i+1] - p_fall[base+i], gap_exp[i]);
    end
  endtask

  // One write with junk on the request port while busy; returns accept-to-ready cycles.
  task automatic write1(input logic r, input logic [7:0] d, input bit junk, output int lat, output int rise);
    int n = 0, b;
    wait_ready();
    b = pn;
    cmd_valid = 1'b1; cmd_rs = r; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (cmd_ready !== 1'b1 && n < 1000) begin
      if (junk) begin cmd_valid = 1'($urandom_range(0, 1)); cmd_rs = 1'($urandom); cmd_data = 8'($urandom); end
      @(negedge clk); n++;
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("write_pulse_count", pn - b, 1);
    chk("write_dat", p_dat[b], d);
    chk("write_rs", p_rs[b], r);
    lat  = rdy_cyc - m_acc_cyc;
    rise = p_rise[b] - m_acc_cyc;
  endtask

  initial begin
    int lat, rise, base, k, n, acc0;
    logic acc;
    logic [7:0] d;
    logic r;
    repeat (3) @(negedge clk);
    chk("reset_en", en, 1'b0);
    chk("reset_busy", busy, 1'b1);
    chk("reset_ready", cmd_ready, 1'b0);
    chk("reset_dat", dat, 8'h00);
    rst = 1'b0;
    wait_init();
    @(negedge clk);
    check_init(0);
    chk("idle_ready", cmd_ready, 1'b1);

    write1(1'b1, 8'h41, 1'b0, lat, rise);
    chk("data_rise_lat", rise, 4);
    chk("data_ready_lat", lat, 13);
    write1(1'b0, 8'h01, 1'b0, lat, rise);
    chk("clear_ready_lat", lat, 20);
    write1(1'b0, 8'h80, 1'b0, lat, rise);
    chk("ddram_ready_lat", lat, 13);
    write1(1'b0, 8'h02, 1'b0, lat, rise);
    chk("home_ready_lat", lat, 20);
    write1(1'b1, 8'h01, 1'b0, lat, rise);
    chk("data01_ready_lat", lat, 13);
    write1(1'b0, 8'h04, 1'b0, lat, rise);
    chk("entry04_ready_lat", lat, 13);

    // Held-valid stream, advanced on each accept.
    base = pn; acc0 = m_accepts; k = 0; n = 0;
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h31;
    while (k < 3 && n < 500) begin
      acc = cmd_ready;
      @(negedge clk); n++;
      if (acc) begin k++; cmd_data = 8'h31 + 8'(k); end
    end
    cmd_valid = 1'b0;
    wait_ready();
    @(negedge clk);
    chk("stream_accepts", m_accepts - acc0, 3);
    chk("stream_pulses", pn - base, 3);
    for (int i = 0; i < 3; i++) chk("stream_dat", p_dat[base+i], 8'h31 + 8'(i));

    for (int i = 0; i < 20; i++) begin
      r = 1'($urandom);
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      write1(r, d, 1'b1, lat, rise);
      chk("rand_ready_lat", lat, 1 + SU + EN + HO + ((!r && d < 8'h04) ? LO : SH));
    end

    // Reset while E is high during a user write.
    wait_ready();
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h5A;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (en !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("pulse_timeout", 0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_en_low", en, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_ready", cmd_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    base = pn;
    wait_init();
    @(negedge clk);
    check_init(base);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
